// File: rtl/dispatch3b3.sv
// ---------------------------------------------------------------------------
// dispatch3b3 -- three-channel round-robin dispatcher with grant-hold timeout
//
// A request in IDLE grants the first enabled channel, searching from the
// round-robin pointer. The grant is held until the selected channel reports
// completion or the hold counter expires. Every grant is followed by a single
// RELEASE cycle before the next arbitration. All state advances only on
// clock-enabled edges.
//
// Parameters
//   TIMEOUT   grant-hold limit in enabled cycles (1..255)
//   INIT_PTR  round-robin pointer value after reset (0..2)
//
// Ports
//   C       in   clock, rising edge
//   R_B     in   synchronous reset, active-low
//   CE      in   clock enable, active-high
//   REQ     in   dispatch request, sampled in IDLE only
//   EN_B    in   [2:0] per-channel enable, active-low (1 masks the channel)
//   DONE_B  in   [2:0] per-channel completion, active-low
//   O_B     out  [2:0] per-channel grant, active-low, one-cold at most
//   SEL     out  [1:0] index of the granted channel, valid while BUSY=1
//   BUSY    out  high in GRANT and RELEASE
//   TOUT    out  one-cycle pulse when a grant ends by timeout
// ---------------------------------------------------------------------------
module dispatch3b3 #(
    parameter logic [7:0] TIMEOUT  = 8'd15,
    parameter logic [1:0] INIT_PTR = 2'd0
) (
    input  logic       C,
    input  logic       R_B,
    input  logic       CE,
    input  logic       REQ,
    input  logic [2:0] EN_B,
    input  logic [2:0] DONE_B,
    output logic [2:0] O_B,
    output logic [1:0] SEL,
    output logic       BUSY,
    output logic       TOUT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [1:0] sel_q,   sel_d;
    logic [2:0] o_b_q,   o_b_d;
    logic       tout_q,  tout_d;

    // The unreachable index 3 is folded onto channel 0.
    function automatic logic [1:0] norm3(input logic [1:0] v);
        return (v == 2'd3) ? 2'd0 : v;
    endfunction

    // Modulo-3 successor of a normalised index.
    function automatic logic [1:0] inc3(input logic [1:0] v);
        case (norm3(v))
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    logic [1:0] sel_n;
    logic [1:0] cand0, cand1, cand2;
    logic [1:0] pick;
    logic       found;

    assign sel_n = norm3(sel_q);
    assign cand0 = norm3(ptr_q);
    assign cand1 = inc3(cand0);
    assign cand2 = inc3(cand1);

    // Round-robin search: first enabled channel at PTR, PTR+1, PTR+2.
    always_comb begin
        found = 1'b1;
        pick  = cand0;
        if (!EN_B[cand0]) begin
            pick = cand0;
        end else if (!EN_B[cand1]) begin
            pick = cand1;
        end else if (!EN_B[cand2]) begin
            pick = cand2;
        end else begin
            found = 1'b0;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        o_b_d   = o_b_q;
        tout_d  = 1'b0;    // pulse: cleared on every edge unless re-asserted

        if (CE) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (REQ && found) begin
                        sel_d   = pick;
                        o_b_d   = ~(3'b001 << pick);
                        cnt_d   = 8'd0;
                        state_d = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Completion is checked first so it wins over a
                    // simultaneous timeout.
                    if (!DONE_B[sel_n]) begin
                        o_b_d   = 3'b111;
                        ptr_d   = inc3(sel_n);
                        state_d = ST_RELEASE;
                    end else if (cnt_q == TIMEOUT - 8'd1) begin
                        o_b_d   = 3'b111;
                        ptr_d   = inc3(sel_n);
                        tout_d  = 1'b1;
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    o_b_d   = 3'b111;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge C) begin
        if (!R_B) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            ptr_q   <= INIT_PTR;
            sel_q   <= 2'd0;
            o_b_q   <= 3'b111;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            o_b_q   <= o_b_d;
            tout_q  <= tout_d;
        end
    end

    assign O_B  = o_b_q;
    assign SEL  = sel_q;
    assign BUSY = (state_q != ST_IDLE);
    assign TOUT = tout_q;

endmodule

// File: tb/tb_dispatch3b3.sv
// ---------------------------------------------------------------------------
// tb_dispatch3b3 -- self-checking bench for dispatch3b3
//
// A transaction-level reference model (granted channel, cycles held, release
// flag, round-robin pointer) is advanced on every rising edge and all DUT
// outputs are compared 1 time unit after the edge. Directed scenarios cover
// the reset state, rotation, masking, timeout, clock enable and reset
// mid-grant; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_dispatch3b3;

    localparam logic [7:0] TO = 8'd4;
    localparam logic [1:0] IP = 2'd0;

    logic       C = 1'b0;
    logic       R_B, CE, REQ;
    logic [2:0] EN_B, DONE_B;
    logic [2:0] O_B;
    logic [1:0] SEL;
    logic       BUSY, TOUT;

    always #5 C = ~C;

    dispatch3b3 #(.TIMEOUT(TO), .INIT_PTR(IP)) dut (
        .C      (C),
        .R_B    (R_B),
        .CE     (CE),
        .REQ    (REQ),
        .EN_B   (EN_B),
        .DONE_B (DONE_B),
        .O_B    (O_B),
        .SEL    (SEL),
        .BUSY   (BUSY),
        .TOUT   (TOUT)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which channel holds the grant (-1 none), how many
    // enabled cycles it has been held, whether we are in the release gap.
    int m_ch   = -1;
    int m_held = 0;
    bit m_rel  = 1'b0;
    int m_ptr  = int'(IP);
    int m_sel  = 0;
    bit m_tout = 1'b0;
    int grants[$];

    task automatic model_edge(input bit rb, input bit ce, input bit req,
                              input logic [2:0] en, input logic [2:0] done);
        if (!rb) begin
            m_ch = -1; m_held = 0; m_rel = 1'b0;
            m_ptr = int'(IP); m_sel = 0; m_tout = 1'b0;
        end else if (ce) begin
            m_tout = 1'b0;
            if (m_rel) begin
                m_rel = 1'b0;
            end else if (m_ch >= 0) begin
                if (!done[m_ch] || m_held == int'(TO)) begin
                    m_tout = done[m_ch] ? 1'b1 : 1'b0;
                    m_ptr  = (m_ch + 1) % 3;
                    m_ch   = -1;
                    m_rel  = 1'b1;
                end else begin
                    m_held++;
                end
            end else if (req) begin
                for (int i = 0; i < 3; i++) begin
                    int c;
                    c = (m_ptr + i) % 3;
                    if (!en[c]) begin
                        m_ch = c; m_sel = c; m_held = 1;
                        grants.push_back(c);
                        break;
                    end
                end
            end
        end else begin
            m_tout = 1'b0;
        end
    endtask

    task automatic tick(input bit rb, input bit ce, input bit req,
                        input logic [2:0] en, input logic [2:0] done);
        logic [2:0] e_ob;
        R_B = rb; CE = ce; REQ = req; EN_B = en; DONE_B = done;
        @(posedge C);
        model_edge(rb, ce, req, en, done);
        #1;
        e_ob = 3'b111;
        if (m_ch >= 0) e_ob[m_ch] = 1'b0;
        check("o_b",  8'(O_B),  8'(e_ob));
        check("sel",  8'(SEL),  8'(m_sel));
        check("busy", 8'(BUSY), 8'(m_ch >= 0 || m_rel));
        check("tout", 8'(TOUT), 8'(m_tout));
    endtask

    // Completion for the granted channel once it has been held 'held' cycles.
    function automatic logic [2:0] done_at(input int held);
        logic [2:0] d;
        d = 3'b111;
        if (m_ch >= 0 && m_held == held) d[m_ch] = 1'b0;
        return d;
    endfunction

    int tout_cnt, low_cnt;

    initial begin
        // Reset state
        tick(0, 1, 0, 3'b000, 3'b111);
        tick(0, 0, 1, 3'b000, 3'b111);
        check("rst_ob", 8'(O_B), 8'h7);
        check("rst_busy", 8'(BUSY), 8'h0);

        // Single grant, completion, release
        tick(1, 1, 1, 3'b000, 3'b111);
        check("g0_ob", 8'(O_B), 8'h6);
        check("g0_sel", 8'(SEL), 8'h0);
        check("g0_busy", 8'(BUSY), 8'h1);
        tick(1, 1, 0, 3'b000, 3'b110);
        check("rel_ob", 8'(O_B), 8'h7);
        check("rel_busy", 8'(BUSY), 8'h1);
        tick(1, 1, 0, 3'b000, 3'b111);
        check("idle_busy", 8'(BUSY), 8'h0);

        // Rotation with REQ held high
        tick(0, 1, 0, 3'b000, 3'b111);
        grants.delete();
        for (int i = 0; i < 16; i++) tick(1, 1, 1, 3'b000, done_at(2));
        check("rr_count", 8'(grants.size() >= 4), 8'h1);
        if (grants.size() >= 4) begin
            check("rr_0", 8'(grants[0]), 8'd0);
            check("rr_1", 8'(grants[1]), 8'd1);
            check("rr_2", 8'(grants[2]), 8'd2);
            check("rr_3", 8'(grants[3]), 8'd0);
        end

        // Masking: EN_B=101 grants channel 1; all masked grants nothing
        tick(0, 1, 0, 3'b000, 3'b111);
        tick(1, 1, 1, 3'b101, 3'b111);
        check("mask_sel", 8'(SEL), 8'h1);
        check("mask_ob", 8'(O_B), 8'h5);
        tick(1, 1, 0, 3'b111, 3'b101);
        tick(1, 1, 0, 3'b111, 3'b111);
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 3'b111, 3'b111);
        check("none_ob", 8'(O_B), 8'h7);
        check("none_busy", 8'(BUSY), 8'h0);

        // Timeout: grant held TIMEOUT cycles then a single TOUT pulse
        tick(0, 1, 0, 3'b000, 3'b111);
        tick(1, 1, 1, 3'b000, 3'b111);
        tout_cnt = 0; low_cnt = 1;
        for (int i = 0; i < 7; i++) begin
            tick(1, 1, 0, 3'b000, 3'b111);
            if (TOUT) tout_cnt++;
            if (O_B != 3'b111) low_cnt++;
        end
        check("to_pulses", 8'(tout_cnt), 8'd1);
        check("to_hold", 8'(low_cnt), 8'(TO));
        tick(1, 1, 1, 3'b000, 3'b111);
        check("to_ptr", 8'(SEL), 8'h1);
        // Completion on the timeout edge: completion wins
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 3'b000, 3'b111);
        tick(1, 1, 0, 3'b000, 3'b101);
        check("done_wins", 8'(TOUT), 8'h0);
        check("done_wins_busy", 8'(BUSY), 8'h1);
        tick(1, 1, 0, 3'b000, 3'b111);

        // Clock enable low mid-grant freezes the grant and delays timeout
        tick(1, 1, 1, 3'b000, 3'b111);
        tick(1, 1, 0, 3'b000, 3'b111);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 3'b000, 3'b111);
        check("ce_hold", 8'(BUSY), 8'h1);
        for (int i = 0; i < 5; i++) tick(1, 1, 0, 3'b000, 3'b111);

        // Reset mid-grant on channel 2
        tick(0, 1, 0, 3'b000, 3'b111);
        tick(1, 1, 1, 3'b011, 3'b111);
        check("ch2_sel", 8'(SEL), 8'h2);
        tick(0, 0, 0, 3'b000, 3'b111);
        check("rst_mid_ob", 8'(O_B), 8'h7);
        check("rst_mid_tout", 8'(TOUT), 8'h0);
        tick(1, 1, 1, 3'b000, 3'b111);
        check("rst_mid_ptr", 8'(SEL), 8'(IP));

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] d;
            d = 3'($urandom);
            if ($urandom_range(0, 3) == 0 && m_ch >= 0) d[m_ch] = 1'b0;
            tick($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) != 0, 3'($urandom), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch3b3.md
DISPATCH3B3 -- requirements
Module: dispatch3b3

Interface
REQ-001 Parameter TIMEOUT, default 8'd15, sets the grant-hold limit in enabled clock cycles (1..255).
REQ-002 Parameter INIT_PTR, default 2'd0, sets the round-robin pointer value after reset (0..2).
REQ-003 C  input  1  clock; all state updates occur on the rising edge.
REQ-004 R_B  input  1  reset; synchronous and active-low.
REQ-005 CE  input  1  clock enable, active-high.
REQ-006 REQ  input  1  dispatch request, active-high.
REQ-007 EN_B  input  3  per-channel enable, active-low; bit n high masks channel n.
REQ-008 DONE_B  input  3  per-channel completion, active-low.
REQ-009 O_B  output  3  per-channel grant, active-low; at most one bit low at a time.
REQ-010 SEL  output  2  index of the granted channel; valid while BUSY=1.
REQ-011 BUSY  output  1  high in states GRANT and RELEASE.
REQ-012 TOUT  output  1  one-cycle pulse when a grant ends by timeout.

Function
REQ-013 FSM states: IDLE, GRANT, RELEASE; 8-bit hold counter CNT; 2-bit pointer PTR.
REQ-014 All transitions, counter updates and pointer updates occur only on edges where CE=1; with CE=0 all state and outputs hold, except that TOUT clears to 0.
REQ-015 IDLE: O_B=3'b111, BUSY=0.
  - REQ=1 and at least one channel enabled -> select the first enabled channel searching PTR, PTR+1, PTR+2 (mod 3).
  - Drive that O_B bit low, load SEL, clear CNT, go to GRANT.
REQ-016 IDLE with REQ=1 and EN_B=3'b111: remain in IDLE with no grant.
REQ-017 Grant latency: REQ sampled high at edge k -> O_B bit low and BUSY=1 immediately after edge k.
REQ-018 GRANT: hold the O_B bit low; CNT increments each enabled cycle.
REQ-019 GRANT exit on DONE_B[SEL]=0 sampled: O_B=3'b111, PTR=(SEL+1) mod 3, go to RELEASE.
REQ-020 GRANT exit on timeout (CNT reaches TIMEOUT-1 while DONE_B[SEL]=1): O_B=3'b111, TOUT=1 for one cycle, PTR=(SEL+1) mod 3, go to RELEASE.
REQ-021 DONE and timeout on the same edge: DONE wins, TOUT stays 0.
REQ-022 DONE_B bits of non-selected channels are ignored in all states.
REQ-023 EN_B changes during GRANT or RELEASE do not affect the current grant; they are used at the next arbitration.
REQ-024 RELEASE lasts exactly one enabled cycle with O_B=3'b111 and BUSY=1, then goes to IDLE.
  - Earliest next grant: 2 enabled edges after the exit edge.
REQ-025 REQ is not sampled in GRANT or RELEASE; REQ=0 during GRANT does not abort the grant.
REQ-026 PTR and SEL values of 3 are unreachable; if reached, they are treated as 0.

Reset
REQ-027 R_B=0 at a rising edge, regardless of CE or state, forces: state=IDLE, O_B=3'b111, SEL=2'd0, BUSY=0, TOUT=0, CNT=0, PTR=INIT_PTR.
REQ-028 Reset during GRANT releases the grant at that edge with no TOUT pulse.

Verification
REQ-029 Reset, EN_B=000, REQ=1 for 1 cycle -> O_B=110, SEL=0, BUSY=1 next cycle; DONE_B=110 -> O_B=111 next cycle, BUSY=0 one cycle later.
REQ-030 REQ held at 1, DONE_B returned 2 cycles after each grant -> grant order ch0, ch1, ch2, ch0, each separated by a 1-cycle RELEASE gap.
REQ-031 EN_B=101, PTR=0, REQ=1 -> channel 1 is granted; EN_B=111 with REQ=1 -> O_B stays 111 and BUSY stays 0.
REQ-032 TIMEOUT=4, no DONE -> O_B bit low for 4 cycles, then TOUT=1 for exactly 1 cycle, PTR advances; DONE and timeout on the same edge -> TOUT=0.
REQ-033 CE=0 for 3 cycles mid-GRANT -> O_B, SEL and CNT frozen; timeout is delayed by 3 cycles.
REQ-034 R_B=0 mid-GRANT on ch2 -> O_B=111 after that edge, PTR=INIT_PTR, next REQ grants channel INIT_PTR.
